spi_counter_ctrl: RTL and testbench

Multi-channel run/stop/clear control and counting block for the SPI counter datapath. Each of NUM_CH independent channels owns a run/stop state machine, a one-cycle clear sequence, a selectable up/down direction and a modulo-MAX_COUNT counter advanced by a shared prescaler tick. Sits between the debounced button/command edge detectors and the SPI transmit framing logic, which samples the count and status outputs.

---
 rtl/spi_counter_pkg.sv | 21 ++
 rtl/spi_counter_ch.sv | 134 +++++++++++++
 rtl/spi_counter_ctrl.sv | 68 ++++++
 tb/tb_spi_counter_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_counter_pkg.sv
// -----------------------------------------------------------------------------
// spi_counter_pkg
// Shared types and constants for the SPI counter control block.
//   ch_state_t         per-channel run/stop/clear state encoding
//   DIR_UP / DIR_DOWN  count direction encoding (o_dir)
//   DEFAULT_MAX_COUNT  default counter modulus
// -----------------------------------------------------------------------------
package spi_counter_pkg;

   typedef enum logic [1:0] {
      STOP  = 2'd0,
      RUN   = 2'd1,
      CLEAR = 2'd2
   } ch_state_t;

   localparam logic DIR_UP   = 1'b0;
   localparam logic DIR_DOWN = 1'b1;

   localparam int DEFAULT_MAX_COUNT = 10000;

endpackage

// File: rtl/spi_counter_ch.sv
// -----------------------------------------------------------------------------
// spi_counter_ch
// One counter channel: run/stop/clear state machine, resume target,
// direction bit and modulo-MAX_COUNT up/down counter with wrap pulse.
//
// Optional feature macro: SPI_CNT_AUTOSTOP_EN
//   defined   : a wrap also drops the channel from RUN to STOP (one-shot)
//   undefined : channel keeps running through wraps (free-running)
//
// Ports
//   clk          system clock, posedge
//   reset        synchronous, active-low reset
//   tick         shared prescaler count enable
//   runstop_req  single-cycle run/stop toggle request
//   clear_req    single-cycle clear request (channel clear OR clear-all)
//   dir_toggle   single-cycle direction toggle request
//   count        registered count, 0..MAX_COUNT-1
//   running      registered, 1 while RUN (or clearing with RUN as resume)
//   clearing     registered one-cycle pulse while in CLEAR
//   dir          registered direction, DIR_UP / DIR_DOWN
//   wrap         registered one-cycle pulse after a modulo wrap
//
// state | meaning
// ------+---------------------------------------------------------------
// STOP  | idle, count held; runstop enters RUN, clear enters CLEAR
// RUN   | count advances on tick; runstop enters STOP, clear enters CLEAR
// CLEAR | single cycle, count already zero; returns to resume target,
//       | every request sampled in this cycle is dropped
// -----------------------------------------------------------------------------
module spi_counter_ch
   import spi_counter_pkg::*;
#(
   parameter int MAX_COUNT = DEFAULT_MAX_COUNT,
   parameter int WIDTH     = $clog2(MAX_COUNT)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             tick,
   input  logic             runstop_req,
   input  logic             clear_req,
   input  logic             dir_toggle,
   output logic [WIDTH-1:0] count,
   output logic             running,
   output logic             clearing,
   output logic             dir,
   output logic             wrap
);

   localparam logic [WIDTH-1:0] CNT_TOP = WIDTH'(MAX_COUNT - 1);

   ch_state_t        state;
   ch_state_t        resume;
   logic [WIDTH-1:0] count_next;
   logic             step_wraps;

   // Next count for one tick in the current (pre-toggle) direction.
   always_comb begin
      count_next = count;
      step_wraps = 1'b0;
      if (dir == DIR_UP) begin
         if (count == CNT_TOP) begin
            count_next = '0;
            step_wraps = 1'b1;
         end else begin
            count_next = count + WIDTH'(1);
         end
      end else begin
         if (count == '0) begin
            count_next = CNT_TOP;
            step_wraps = 1'b1;
         end else begin
            count_next = count - WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= STOP;
         resume   <= STOP;
         count    <= '0;
         running  <= 1'b0;
         clearing <= 1'b0;
         dir      <= DIR_UP;
         wrap     <= 1'b0;
      end else begin
         clearing <= 1'b0;
         wrap     <= 1'b0;
         case (state)
            STOP, RUN: begin
               // Register update is non-blocking, so a coincident tick
               // below still counts in the old direction.
               if (dir_toggle) dir <= ~dir;

               if (clear_req) begin
                  // Clear wins over runstop; running keeps reflecting the
                  // resume target through the CLEAR cycle.
                  state    <= CLEAR;
                  resume   <= state;
                  count    <= '0;
                  clearing <= 1'b1;
               end else if (runstop_req) begin
                  // Tick coincident with entering or leaving RUN is dropped.
                  if (state == RUN) begin
                     state   <= STOP;
                     running <= 1'b0;
                  end else begin
                     state   <= RUN;
                     running <= 1'b1;
                  end
               end else if (state == RUN && tick) begin
                  count <= count_next;
                  wrap  <= step_wraps;
`ifdef SPI_CNT_AUTOSTOP_EN
                  if (step_wraps) begin
                     state   <= STOP;
                     running <= 1'b0;
                  end
`endif
               end
            end
            CLEAR: begin
               state <= resume;
            end
            default: begin
               state   <= STOP;
               resume  <= STOP;
               running <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/spi_counter_ctrl.sv
// -----------------------------------------------------------------------------
// spi_counter_ctrl
// Multi-channel run/stop/clear control and counting block feeding the SPI
// transmit framing logic. NUM_CH independent channels share only the
// prescaler tick and the clear-all request.
//
// Optional feature macro: SPI_CNT_AUTOSTOP_EN (one-shot stop on wrap, see
// spi_counter_ch).
//
// Ports
//   clk           system clock, posedge
//   reset         synchronous, active-low reset
//   i_tick        shared single-cycle count enable
//   i_runstop     per-channel run/stop toggle request
//   i_clear       per-channel clear request
//   i_dir_toggle  per-channel direction toggle request
//   i_clear_all   clear request for every channel
//   o_count       packed counts, channel c at [c*WIDTH +: WIDTH]
//   o_runstop     1 = channel running
//   o_clear       one-cycle pulse while channel is in CLEAR
//   o_dir         0 = up, 1 = down
//   o_wrap        one-cycle pulse after a modulo wrap
// -----------------------------------------------------------------------------
module spi_counter_ctrl
   import spi_counter_pkg::*;
#(
   parameter int NUM_CH    = 4,
   parameter int MAX_COUNT = DEFAULT_MAX_COUNT,
   parameter int WIDTH     = $clog2(MAX_COUNT)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    i_tick,
   input  logic [NUM_CH-1:0]       i_runstop,
   input  logic [NUM_CH-1:0]       i_clear,
   input  logic [NUM_CH-1:0]       i_dir_toggle,
   input  logic                    i_clear_all,
   output logic [NUM_CH*WIDTH-1:0] o_count,
   output logic [NUM_CH-1:0]       o_runstop,
   output logic [NUM_CH-1:0]       o_clear,
   output logic [NUM_CH-1:0]       o_dir,
   output logic [NUM_CH-1:0]       o_wrap
);

   logic [NUM_CH-1:0] clear_eff;

   assign clear_eff = i_clear | {NUM_CH{i_clear_all}};

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      spi_counter_ch #(
         .MAX_COUNT (MAX_COUNT),
         .WIDTH     (WIDTH)
      ) u_ch (
         .clk         (clk),
         .reset       (reset),
         .tick        (i_tick),
         .runstop_req (i_runstop[g]),
         .clear_req   (clear_eff[g]),
         .dir_toggle  (i_dir_toggle[g]),
         .count       (o_count[g*WIDTH +: WIDTH]),
         .running     (o_runstop[g]),
         .clearing    (o_clear[g]),
         .dir         (o_dir[g]),
         .wrap        (o_wrap[g])
      );
   end

endmodule

// File: tb/tb_spi_counter_ctrl.sv
module tb_spi_counter_ctrl;

   localparam int NCH = 4;
   localparam int W   = 14;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             i_tick = 1'b0;
   logic [NCH-1:0]   i_runstop = '0;
   logic [NCH-1:0]   i_clear = '0;
   logic [NCH-1:0]   i_dir_toggle = '0;
   logic             i_clear_all = 1'b0;
   logic [NCH*W-1:0] o_count;
   logic [NCH-1:0]   o_runstop, o_clear, o_dir, o_wrap;

   spi_counter_ctrl dut (
      .clk          (clk),
      .reset        (reset),
      .i_tick       (i_tick),
      .i_runstop    (i_runstop),
      .i_clear      (i_clear),
      .i_dir_toggle (i_dir_toggle),
      .i_clear_all  (i_clear_all),
      .o_count      (o_count),
      .o_runstop    (o_runstop),
      .o_clear      (o_clear),
      .o_dir        (o_dir),
      .o_wrap       (o_wrap)
   );

   always #5 clk = ~clk;

   typedef struct {
      int               due;
      string            name;
      logic [NCH*W-1:0] cnt;
      logic [NCH-1:0]   run, clr, dir, wrap;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;

   int             e_cnt [NCH];
   logic [NCH-1:0] e_run = '0, e_clr = '0, e_dir = '0, e_wrap = '0;

   always @(posedge clk) cyc++;

   // Monitor: compares every expectation that has come due.
   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].due <= cyc) begin
         exp_t e;
         e = sb.pop_front();
         n_checks++;
         if (o_count !== e.cnt) begin
            n_fail++;
            $display("FAIL %s count: got %h want %h", e.name, o_count, e.cnt);
         end
         n_checks++;
         if (o_runstop !== e.run) begin
            n_fail++;
            $display("FAIL %s runstop: got %b want %b", e.name, o_runstop, e.run);
         end
         n_checks++;
         if (o_clear !== e.clr) begin
            n_fail++;
            $display("FAIL %s clear: got %b want %b", e.name, o_clear, e.clr);
         end
         n_checks++;
         if (o_dir !== e.dir) begin
            n_fail++;
            $display("FAIL %s dir: got %b want %b", e.name, o_dir, e.dir);
         end
         n_checks++;
         if (o_wrap !== e.wrap) begin
            n_fail++;
            $display("FAIL %s wrap: got %b want %b", e.name, o_wrap, e.wrap);
         end
      end
   end

   task automatic push(input string name);
      exp_t e;
      e.due  = cyc + 1;
      e.name = name;
      for (int c = 0; c < NCH; c++) e.cnt[c*W +: W] = e_cnt[c][W-1:0];
      e.run  = e_run;
      e.clr  = e_clr;
      e.dir  = e_dir;
      e.wrap = e_wrap;
      sb.push_back(e);
   endtask

   // One clock of stimulus; the expectation describes outputs after the edge
   // that samples these inputs.
   task automatic step(input logic t, input logic [NCH-1:0] rs, input logic [NCH-1:0] cl,
                       input logic [NCH-1:0] dt, input logic ca, input logic rst_n,
                       input bit chk, input string name);
      @(posedge clk);
      #1;
      reset        = rst_n;
      i_tick       = t;
      i_runstop    = rs;
      i_clear      = cl;
      i_dir_toggle = dt;
      i_clear_all  = ca;
      if (chk) push(name);
      e_clr  = '0;
      e_wrap = '0;
   endtask

   initial begin
      for (int c = 0; c < NCH; c++) e_cnt[c] = 0;

      // Reset and idle ticks
      step(1'b0, '0, '0, '0, 1'b0, 1'b0, 1, "reset0");
      step(1'b1, 4'hF, 4'hF, 4'hF, 1'b1, 1'b0, 1, "reset1");
      for (int i = 0; i < 100; i++) step(1'b1, '0, '0, '0, 1'b0, 1'b1, 1, "idle_tick");

      // Ch0: start (coincident tick dropped), 5 ticks, stop (tick dropped), 3 ticks
      e_run[0] = 1'b1;
      step(1'b1, 4'b0001, '0, '0, 1'b0, 1'b1, 1, "ch0_start");
      for (int i = 1; i <= 5; i++) begin
         e_cnt[0] = i;
         step(1'b1, '0, '0, '0, 1'b0, 1'b1, 1, "ch0_count");
      end
      e_run[0] = 1'b0;
      step(1'b1, 4'b0001, '0, '0, 1'b0, 1'b1, 1, "ch0_stop");
      for (int i = 0; i < 3; i++) step(1'b1, '0, '0, '0, 1'b0, 1'b1, 1, "ch0_held");

      // Ch1: run up to 9998, then up-wrap
      e_run[1] = 1'b1;
      step(1'b0, 4'b0010, '0, '0, 1'b0, 1'b1, 1, "ch1_start");
      for (int i = 1; i <= 9998; i++) begin
         e_cnt[1] = i;
         step(1'b1, '0, '0, '0, 1'b0, 1'b1, (i == 9998), "ch1_to_9998");
      end
      e_cnt[1] = 9999;
      step(1'b1, '0, '0, '0, 1'b0, 1'b1, 1, "ch1_9999");
      e_cnt[1]  = 0;
      e_wrap[1] = 1'b1;
`ifdef SPI_CNT_AUTOSTOP_EN
      e_run[1]  = 1'b0;
`endif
      step(1'b1, '0, '0, '0, 1'b0, 1'b1, 1, "ch1_up_wrap");
      step(1'b0, '0, '0, '0, 1'b0, 1'b1, 1, "ch1_wrap_drop");
`ifdef SPI_CNT_AUTOSTOP_EN
      e_run[1] = 1'b1;
      step(1'b0, 4'b0010, '0, '0, 1'b0, 1'b1, 1, "ch1_restart");
`endif
      // Toggle to down, then down-wrap from 0
      e_dir[1] = 1'b1;
      step(1'b0, '0, '0, 4'b0010, 1'b0, 1'b1, 1, "ch1_dir_down");
      e_cnt[1]  = 9999;
      e_wrap[1] = 1'b1;
`ifdef SPI_CNT_AUTOSTOP_EN
      e_run[1]  = 1'b0;
`endif
      step(1'b1, '0, '0, '0, 1'b0, 1'b1, 1, "ch1_down_wrap");
      step(1'b0, '0, '0, '0, 1'b0, 1'b1, 1, "ch1_wrap_drop2");
`ifdef SPI_CNT_AUTOSTOP_EN
      e_run[1] = 1'b1;
      step(1'b0, 4'b0010, '0, '0, 1'b0, 1'b1, 1, "ch1_restart2");
`endif
      // Toggle coincident with tick: tick still counts down
      e_cnt[1] = 9998;
      e_dir[1] = 1'b0;
      step(1'b1, '0, '0, 4'b0010, 1'b0, 1'b1, 1, "ch1_toggle_tick");
      e_cnt[1] = 9999;
      step(1'b1, '0, '0, '0, 1'b0, 1'b1, 1, "ch1_up_again");
      e_run[1] = 1'b0;
      step(1'b0, 4'b0010, '0, '0, 1'b0, 1'b1, 1, "ch1_stop");

      // Ch2: run to 37, clear+runstop together
      e_run[2] = 1'b1;
      step(1'b0, 4'b0100, '0, '0, 1'b0, 1'b1, 1, "ch2_start");
      for (int i = 1; i <= 37; i++) begin
         e_cnt[2] = i;
         step(1'b1, '0, '0, '0, 1'b0, 1'b1, (i == 37), "ch2_to_37");
      end
      e_cnt[2] = 0;
      e_clr[2] = 1'b1;
      step(1'b1, 4'b0100, 4'b0100, '0, 1'b0, 1'b1, 1, "ch2_clear_beats_rs");
      step(1'b1, 4'b0100, '0, 4'b0100, 1'b0, 1'b1, 1, "ch2_clear_cycle_ignored");
      e_cnt[2] = 1;
      step(1'b1, '0, '0, '0, 1'b0, 1'b1, 1, "ch2_resumed");

      // Clear-all with every channel running
      e_run = 4'b1111;
      step(1'b0, 4'b1011, '0, '0, 1'b0, 1'b1, 1, "all_start");
      e_dir[1] = 1'b1;
      step(1'b0, '0, '0, 4'b0010, 1'b0, 1'b1, 1, "ch1_dir_down2");
      e_cnt[0] = 6; e_cnt[1] = 9998; e_cnt[2] = 2; e_cnt[3] = 1;
      step(1'b1, '0, '0, '0, 1'b0, 1'b1, 1, "all_tick");
      for (int c = 0; c < NCH; c++) e_cnt[c] = 0;
      e_clr = 4'b1111;
      step(1'b1, '0, '0, '0, 1'b1, 1'b1, 1, "clear_all");
      step(1'b1, '0, '0, '0, 1'b0, 1'b1, 1, "clear_all_cycle");
      step(1'b0, '0, '0, '0, 1'b0, 1'b1, 1, "clear_all_resumed");

      // Ch3 at 50, reset during CLEAR
      e_run = 4'b1000;
      step(1'b0, 4'b0111, '0, '0, 1'b0, 1'b1, 1, "stop_012");
      for (int i = 1; i <= 50; i++) begin
         e_cnt[3] = i;
         step(1'b1, '0, '0, '0, 1'b0, 1'b1, (i == 50), "ch3_to_50");
      end
      e_cnt[3] = 0;
      e_clr[3] = 1'b1;
      step(1'b0, '0, 4'b1000, '0, 1'b0, 1'b1, 1, "ch3_clear");
      e_run = '0;
      e_dir = '0;
      step(1'b1, 4'b1000, '0, 4'b1000, 1'b0, 1'b0, 1, "reset_in_clear");
      step(1'b0, '0, '0, '0, 1'b0, 1'b1, 1, "post_reset_idle");
      step(1'b1, '0, '0, '0, 1'b0, 1'b1, 1, "post_reset_stopped");

      // Drain with a bounded wait
      for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
      @(negedge clk);
      #1;
      if (sb.size() > 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain: %0d expectations pending, want 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
